// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver driven by an oversampled baud enable
// Synchronises rxd, validates the start bit at its centre and samples data and stop bits at their centres.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 rxd,
   input  logic                 clr_rda,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rda,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // The edge-detect enable is tick 0, so the start centre (tick OVERSAMPLE/2-1)
   // is the enable on which the counter still holds OVERSAMPLE/2-2.
   localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2 - 2);
   localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                 state;
   logic   [TW-1:0]        tick_cnt;
   logic   [BW-1:0]        bit_cnt;
   logic   [DATA_BITS-1:0] shift_reg;
   logic                   rxd_meta;
   logic                   rxd_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rda       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // Frame completion below overrides this when both land in the same cycle.
         if (clr_rda) begin
            rda     <= 1'b0;
            overrun <= 1'b0;
         end
         if (enable) begin
            case (state)
               IDLE: begin
                  if (!rxd_sync) begin
                     state    <= START;
                     tick_cnt <= '0;
                  end
               end
               START: begin
                  tick_cnt <= tick_cnt + TW'(1);
                  if (tick_cnt == TICK_START) begin
                     if (!rxd_sync) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               DATA: begin
                  tick_cnt <= tick_cnt + TW'(1);
                  if (tick_cnt == TICK_LAST) begin
                     shift_reg <= DATA_BITS'({rxd_sync, shift_reg} >> 1);
                     if (bit_cnt == BIT_LAST) begin
                        state    <= STOP;
                        tick_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end
               end
               STOP: begin
                  tick_cnt <= tick_cnt + TW'(1);
                  if (tick_cnt == TICK_LAST) begin
                     rx_data   <= shift_reg;
                     rda       <= 1'b1;
                     frame_err <= ~rxd_sync;
                     overrun   <= overrun | rda;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
